// File: rtl/pc_unit_if.sv
// Fetch-side bundle of the program-counter unit: control in, PC and RAS status out.
// The master drives stall/op/dataIn; the slave (pc_unit) drives the PC and status flags.
interface pc_unit_if #(
   parameter int WIDTH = 16
);
   logic             stall;
   logic [2:0]       op;
   logic [WIDTH-1:0] dataIn;
   logic [WIDTH-1:0] cnt;
   logic             ras_full;
   logic             ras_empty;
   logic             ras_err;
   logic             fault;

   modport master (
      output stall, op, dataIn,
      input  cnt, ras_full, ras_empty, ras_err, fault
   );

   modport slave (
      input  stall, op, dataIn,
      output cnt, ras_full, ras_empty, ras_err, fault
   );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: SEQ/JMP/BR/CALL/RET/LOAD with a circular return-address stack.
// Optional PC upper-bound check is enabled by defining PC_BOUNDS_EN.
module pc_unit #(
   parameter int               WIDTH     = 16,
   parameter int               INC       = 1,
   parameter logic [WIDTH-1:0] RST_VEC   = '0,
   parameter int               RAS_DEPTH = 4,
   parameter logic [WIDTH-1:0] PC_LIMIT  = '1
) (
   input logic       clk,
   input logic       rst,
   pc_unit_if.slave  bus
);

   localparam int               PW      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int               CW      = $clog2(RAS_DEPTH + 1);
   localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
   localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);

   localparam logic [2:0] OP_SEQ  = 3'b000;
   localparam logic [2:0] OP_JMP  = 3'b001;
   localparam logic [2:0] OP_BR   = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_RET  = 3'b100;
   localparam logic [2:0] OP_LOAD = 3'b101;

   logic [WIDTH-1:0] cnt_r;
   logic             fault_r;
   logic             ras_err_r;
   logic             ras_full_r;
   logic             ras_empty_r;
   logic [PW-1:0]    top_r;
   logic [CW-1:0]    count_r;
   logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];

   logic [WIDTH-1:0] seq_pc_s;
   logic [WIDTH-1:0] next_pc_s;
   logic [WIDTH-1:0] final_pc_s;
   logic             push_s;
   logic             pop_s;
   logic             err_s;
   logic             fault_s;
   logic [PW-1:0]    wr_ptr_s;
   logic [PW-1:0]    top_next_s;
   logic [CW-1:0]    count_next_s;

   assign seq_pc_s = cnt_r + INC_W;
   assign wr_ptr_s = top_r + PW'(1);

   // Next-PC selection and stack push/pop/error decode from op
   always_comb begin
      next_pc_s = seq_pc_s;
      push_s    = 1'b0;
      pop_s     = 1'b0;
      err_s     = 1'b0;
      case (bus.op)
         OP_SEQ:  next_pc_s = seq_pc_s;
         OP_JMP:  next_pc_s = bus.dataIn;
         OP_LOAD: next_pc_s = bus.dataIn;
         OP_BR:   next_pc_s = cnt_r + bus.dataIn;
         OP_CALL: begin
            next_pc_s = bus.dataIn;
            push_s    = 1'b1;
            err_s     = (count_r == DEPTH_C);
         end
         OP_RET: begin
            // An empty stack degrades RET to a sequential step
            if (count_r != '0) begin
               next_pc_s = ras_mem_r[top_r];
               pop_s     = 1'b1;
            end else begin
               next_pc_s = seq_pc_s;
               err_s     = 1'b1;
            end
         end
         default: next_pc_s = seq_pc_s;
      endcase
   end

   // Stack pointer and occupancy update; a full push overwrites the oldest slot
   always_comb begin
      top_next_s   = top_r;
      count_next_s = count_r;
      if (push_s) begin
         top_next_s = wr_ptr_s;
         if (count_r != DEPTH_C) begin
            count_next_s = count_r + CW'(1);
         end else begin
            count_next_s = count_r;
         end
      end else if (pop_s) begin
         top_next_s   = top_r - PW'(1);
         count_next_s = count_r - CW'(1);
      end else begin
         top_next_s   = top_r;
         count_next_s = count_r;
      end
   end

`ifdef PC_BOUNDS_EN
   // Out-of-range targets are redirected to the reset vector and flagged
   always_comb begin
      if (next_pc_s > PC_LIMIT) begin
         fault_s    = 1'b1;
         final_pc_s = RST_VEC;
      end else begin
         fault_s    = 1'b0;
         final_pc_s = next_pc_s;
      end
   end
`else
   logic unused_limit_s;
   assign unused_limit_s = ^PC_LIMIT;
   assign fault_s        = 1'b0;
   assign final_pc_s     = next_pc_s;
`endif

   // PC, stack bookkeeping and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r       <= RST_VEC;
         fault_r     <= 1'b0;
         ras_err_r   <= 1'b0;
         ras_full_r  <= 1'b0;
         ras_empty_r <= 1'b1;
         top_r       <= '0;
         count_r     <= '0;
      end else if (bus.stall) begin
         fault_r <= 1'b0;
      end else begin
         cnt_r       <= final_pc_s;
         fault_r     <= fault_s;
         ras_err_r   <= ras_err_r | err_s;
         ras_full_r  <= (count_next_s == DEPTH_C);
         ras_empty_r <= (count_next_s == '0);
         top_r       <= top_next_s;
         count_r     <= count_next_s;
      end
   end

   // Return-address storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (!rst && !bus.stall && push_s) begin
         ras_mem_r[wr_ptr_s] <= seq_pc_s;
      end
   end

   assign bus.cnt       = cnt_r;
   assign bus.fault     = fault_r;
   assign bus.ras_err   = ras_err_r;
   assign bus.ras_full  = ras_full_r;
   assign bus.ras_empty = ras_empty_r;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a reference model pushes expected state into a scoreboard
// queue as each step is driven; entries are popped and compared after the clock edge.
module tb_pc_unit;

   logic clk;
   logic rst;

   pc_unit_if #(.WIDTH(16)) bus ();

   pc_unit #(
      .WIDTH    (16),
      .INC      (1),
      .RST_VEC  (16'h0000),
      .RAS_DEPTH(4),
      .PC_LIMIT (16'h00FF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      string       tag;
      logic [15:0] cnt;
      logic        full;
      logic        empty;
      logic        err;
      logic        fault;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] m_stack[$];
   logic [15:0] m_pc;
   logic        m_err;
   logic        m_fault;
   int          errors;
   int          checks;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, advance the model, queue its expectation, then compare after the edge
   task automatic step(input string tag, input logic r, input logic s,
                       input logic [2:0] o, input logic [15:0] d);
      logic [15:0] nxt;
      exp_t        e;
      exp_t        got;
      rst        = r;
      bus.stall  = s;
      bus.op     = o;
      bus.dataIn = d;
      if (r) begin
         m_pc = 16'h0000;
         m_stack.delete();
         m_err   = 1'b0;
         m_fault = 1'b0;
      end else if (s) begin
         m_fault = 1'b0;
      end else begin
         nxt = m_pc + 16'd1;
         case (o)
            3'b001, 3'b101: nxt = d;
            3'b010:         nxt = m_pc + d;
            3'b011: begin
               m_stack.push_back(m_pc + 16'd1);
               if (m_stack.size() > 4) begin
                  void'(m_stack.pop_front());
                  m_err = 1'b1;
               end
               nxt = d;
            end
            3'b100: begin
               if (m_stack.size() == 0) m_err = 1'b1;
               else nxt = m_stack.pop_back();
            end
            default: nxt = m_pc + 16'd1;
         endcase
         m_fault = 1'b0;
`ifdef PC_BOUNDS_EN
         if (nxt > 16'h00FF) begin
            nxt     = 16'h0000;
            m_fault = 1'b1;
         end
`endif
         m_pc = nxt;
      end
      e.tag   = tag;
      e.cnt   = m_pc;
      e.full  = (m_stack.size() == 4);
      e.empty = (m_stack.size() == 0);
      e.err   = m_err;
      e.fault = m_fault;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk({got.tag, ".cnt"},   bus.cnt,               got.cnt);
      chk({got.tag, ".full"},  {15'd0, bus.ras_full},  {15'd0, got.full});
      chk({got.tag, ".empty"}, {15'd0, bus.ras_empty}, {15'd0, got.empty});
      chk({got.tag, ".err"},   {15'd0, bus.ras_err},   {15'd0, got.err});
      chk({got.tag, ".fault"}, {15'd0, bus.fault},     {15'd0, got.fault});
   endtask

   initial begin
      errors = 0;
      checks = 0;
      m_pc   = 16'h0000;
      m_err  = 1'b0;
      m_fault = 1'b0;

      step("reset", 1'b1, 1'b0, 3'b000, 16'h0000);
      chk("reset_cnt", bus.cnt, 16'h0000);
      step("seq1", 1'b0, 1'b0, 3'b000, 16'h0000);
      step("seq2", 1'b0, 1'b0, 3'b000, 16'h0000);
      step("seq3", 1'b0, 1'b0, 3'b000, 16'h0000);
`ifndef PC_BOUNDS_EN
      chk("seq_const", bus.cnt, 16'h0003);

      step("load_ffff", 1'b0, 1'b0, 3'b101, 16'hFFFF);
      step("wrap", 1'b0, 1'b0, 3'b000, 16'h0000);
      chk("wrap_const", bus.cnt, 16'h0000);
      step("br_neg", 1'b0, 1'b0, 3'b010, 16'hFFFE);
      chk("br_const", bus.cnt, 16'hFFFE);
      step("br_pos", 1'b0, 1'b0, 3'b010, 16'h0010);
      step("rsv6", 1'b0, 1'b0, 3'b110, 16'h7777);
      step("rsv7", 1'b0, 1'b0, 3'b111, 16'h7777);

      step("load_10", 1'b0, 1'b0, 3'b101, 16'h0010);
      step("call_100", 1'b0, 1'b0, 3'b011, 16'h0100);
      step("call_200", 1'b0, 1'b0, 3'b011, 16'h0200);
      step("ret1", 1'b0, 1'b0, 3'b100, 16'h0000);
      chk("ret1_const", bus.cnt, 16'h0101);
      step("ret2", 1'b0, 1'b0, 3'b100, 16'h0000);
      chk("ret2_const", bus.cnt, 16'h0011);
      chk("callret_err", {15'd0, bus.ras_err}, 16'h0000);

      for (int i = 0; i < 5; i++)
         step("ovf_call", 1'b0, 1'b0, 3'b011, 16'h1000 + 16'(i) * 16'h0100);
      chk("ovf_full", {15'd0, bus.ras_full}, 16'h0001);
      chk("ovf_err", {15'd0, bus.ras_err}, 16'h0001);
      for (int i = 0; i < 4; i++)
         step("ovf_ret", 1'b0, 1'b0, 3'b100, 16'h0000);
      chk("ovf_ret_const", bus.cnt, 16'h1001);
      step("unf_ret", 1'b0, 1'b0, 3'b100, 16'h0000);
      chk("unf_const", bus.cnt, 16'h1002);

      step("stall_jmp", 1'b0, 1'b1, 3'b001, 16'h1234);
      chk("stall_const", bus.cnt, 16'h1002);
      step("stall_ret", 1'b0, 1'b1, 3'b100, 16'h0000);
      step("call_500", 1'b0, 1'b0, 3'b011, 16'h0500);
      step("push_stall", 1'b0, 1'b1, 3'b011, 16'h0600);
      step("rst_prio", 1'b1, 1'b1, 3'b011, 16'h0700);
      chk("rst_prio_const", bus.cnt, 16'h0000);
      step("post_rst_ret", 1'b0, 1'b0, 3'b100, 16'h0000);
`else
      step("jmp_over", 1'b0, 1'b0, 3'b001, 16'h0100);
      chk("fault_pulse", {15'd0, bus.fault}, 16'h0001);
      step("after_fault", 1'b0, 1'b0, 3'b000, 16'h0000);
      step("jmp_limit", 1'b0, 1'b0, 3'b001, 16'h00FF);
      chk("limit_nofault", {15'd0, bus.fault}, 16'h0000);
      step("seq_over", 1'b0, 1'b0, 3'b000, 16'h0000);
      step("call_over", 1'b0, 1'b0, 3'b011, 16'h0200);
      step("ret_fault_ra", 1'b0, 1'b0, 3'b100, 16'h0000);
      step("stall_fault", 1'b0, 1'b1, 3'b001, 16'h0300);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
